logic_capture: RTL and testbench

LOGIC_CAPTURE -- requirements
Module: logic_capture

---
 rtl/logic_capture.sv | 132 +++++++++++++
 tb/tb_logic_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/logic_capture.sv
// Small logic analyser: arms on request, stores probe samples around a masked-value trigger,
// then replays the capture oldest-first over a valid/ready stream.
module logic_capture #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm,
   input  logic [WIDTH-1:0] probe,
   input  logic [WIDTH-1:0] trig_mask,
   input  logic [WIDTH-1:0] trig_value,
   input  logic [AW-1:0]    post_count,
   input  logic             rd_start,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_last,
   output logic             busy,
   output logic             done,
   output logic [AW:0]      trig_pos
);

   typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE, ST_READ} state_t;

   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] L_ONE  = (AW+1)'(1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_fill;
   logic [AW-1:0]    r_remaining;
   logic [AW-1:0]    r_post;
   logic [AW:0]      r_rd_idx;
   logic [AW:0]      r_n;
   logic [AW-1:0]    r_oldest;
   logic [AW:0]      r_trig_pos;

   logic             w_hit;
   logic             w_wr_en;
   logic [AW:0]      w_fill_inc;
   logic             w_done_entry;
   logic             w_xfer;
   logic             w_last;
   logic [AW-1:0]    w_rd_addr;

   assign w_hit        = ((probe ^ trig_value) & trig_mask) == '0;
   assign w_wr_en      = (r_state == ST_ARMED || r_state == ST_POST) && !arm;
   assign w_fill_inc   = (r_fill == L_FULL) ? r_fill : r_fill + L_ONE;
   assign w_xfer       = (r_state == ST_READ) && rd_ready;
   assign w_last       = (r_rd_idx == r_n - L_ONE);
   assign w_done_entry = (w_next == ST_DONE) && (r_state != ST_DONE);
   assign w_rd_addr    = r_oldest + r_rd_idx[AW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (arm) w_next = ST_ARMED;
         ST_ARMED: begin
            if (arm)        w_next = ST_ARMED;
            else if (w_hit) w_next = (r_post == '0) ? ST_DONE : ST_POST;
         end
         ST_POST: begin
            if (arm)                          w_next = ST_ARMED;
            else if (r_remaining <= AW'(1))   w_next = ST_DONE;
         end
         ST_DONE: begin
            if (arm)           w_next = ST_ARMED;
            else if (rd_start) w_next = ST_READ;
         end
         ST_READ:  if (w_xfer && w_last) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // NOTE: sample storage has no reset; contents survive idle periods and reset is never needed for it.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= probe;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_remaining <= '0;
         r_post      <= '0;
         r_rd_idx    <= '0;
         r_n         <= '0;
         r_oldest    <= '0;
         r_trig_pos  <= '0;
      end else begin
         // arm takes priority over the write of the same cycle
         if (arm && r_state != ST_READ) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_post   <= post_count;
         end else if (w_wr_en) begin
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_fill      <= w_fill_inc;
            r_remaining <= (r_state == ST_ARMED) ? r_post : r_remaining - 1'b1;
         end

         if (w_done_entry) begin
            r_n        <= w_fill_inc;
            r_trig_pos <= w_fill_inc - L_ONE - {1'b0, r_post};
            r_oldest   <= (w_fill_inc == L_FULL) ? r_wr_ptr + 1'b1 : '0;
         end

         if (r_state == ST_DONE && w_next == ST_READ) r_rd_idx <= '0;
         else if (w_xfer)                             r_rd_idx <= r_rd_idx + L_ONE;
      end
   end

   always_comb begin
      rd_valid = (r_state == ST_READ);
      rd_last  = (r_state == ST_READ) && w_last;
      rd_data  = (r_state == ST_READ) ? r_mem[w_rd_addr] : '0;
      busy     = (r_state == ST_ARMED) || (r_state == ST_POST);
      done     = (r_state == ST_DONE);
      trig_pos = r_trig_pos;
   end

endmodule

// File: tb/tb_logic_capture.sv
// Directed bench for logic_capture: capture, wrap, backpressure, immediate trigger,
// re-arm, asynchronous reset during readout and arm/rd_start collision.
module tb_logic_capture;

   logic       clk;
   logic       reset;
   logic       arm;
   logic [3:0] probe;
   logic [3:0] trig_mask;
   logic [3:0] trig_value;
   logic [3:0] post_count;
   logic       rd_start;
   logic       rd_ready;
   logic       rd_valid;
   logic [3:0] rd_data;
   logic       rd_last;
   logic       busy;
   logic       done;
   logic [4:0] trig_pos;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] exp_d [16];

   logic_capture #(.WIDTH(4), .DEPTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .arm        (arm),
      .probe      (probe),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .post_count (post_count),
      .rd_start   (rd_start),
      .rd_ready   (rd_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_last    (rd_last),
      .busy       (busy),
      .done       (done),
      .trig_pos   (trig_pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [3:0] m, input logic [3:0] v, input logic [3:0] pc);
      trig_mask  = m;
      trig_value = v;
      post_count = pc;
      arm        = 1'b1;
      tick();
      arm        = 1'b0;
   endtask

   // Readout of n samples against exp_d; bp applies the 1,0,0,1 ready pattern.
   task automatic drain(input int n, input bit bp);
      int k   = 0;
      int cyc = 0;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      while (k < n && cyc < 64) begin
         rd_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         check($sformatf("rd_valid[%0d]", k), 32'(rd_valid), 32'(1));
         check($sformatf("rd_data[%0d]", k), 32'(rd_data), 32'(exp_d[k]));
         check($sformatf("rd_last[%0d]", k), 32'(rd_last), 32'(k == n - 1));
         tick();
         if (rd_ready) k++;
         cyc++;
      end
      rd_ready = 1'b1;
      check("drain_count", k, n);
      check("rd_valid_end", 32'(rd_valid), 32'(0));
      check("done_end", 32'(done), 32'(0));
   endtask

   initial begin
      reset = 1'b0; arm = 1'b0; probe = '0; trig_mask = '0; trig_value = '0;
      post_count = '0; rd_start = 1'b0; rd_ready = 1'b1;

      #1;
      check("rst_valid", 32'(rd_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_data", 32'(rd_data), 32'(0));
      check("rst_trig", 32'(trig_pos), 32'(0));
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("post_rst_last", 32'(rd_last), 32'(0));
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("idle_rdstart_ignored", 32'(rd_valid), 32'(0));

      // Short capture: ramp 0.. from first ARMED cycle, trigger on A, 3 post samples.
      do_arm(4'hF, 4'hA, 4'd3);
      for (int i = 0; i < 14; i++) begin
         probe = 4'(i);
         tick();
         if (i == 0) check("t1_busy", 32'(busy), 32'(1));
      end
      check("t1_done", 32'(done), 32'(1));
      check("t1_busy_off", 32'(busy), 32'(0));
      check("t1_trig_pos", 32'(trig_pos), 32'(10));
      probe = 4'hE; tick();
      probe = 4'hF; tick();
      for (int i = 0; i < 14; i++) exp_d[i] = 4'(i);
      drain(14, 1'b0);

      // Wrap with backpressure: arm while probe=3, trigger on the next 3.
      for (int i = 0; i < 3; i++) begin probe = 4'(i); tick(); end
      probe = 4'h3;
      do_arm(4'hF, 4'h3, 4'd2);
      for (int i = 4; i < 22; i++) begin probe = 4'(i); tick(); end
      check("t2_done", 32'(done), 32'(1));
      check("t2_trig_pos", 32'(trig_pos), 32'(13));
      for (int i = 0; i < 16; i++) exp_d[i] = 4'(i + 6);
      drain(16, 1'b1);

      // Immediate trigger with mask 0 and post_count 0.
      probe = 4'h7;
      do_arm(4'h0, 4'h0, 4'd0);
      tick();
      check("t3_done", 32'(done), 32'(1));
      check("t3_trig_pos", 32'(trig_pos), 32'(0));
      exp_d[0] = 4'h7;
      drain(1, 1'b0);

      // Re-arm in POST restarts with an empty buffer.
      do_arm(4'hF, 4'h5, 4'd4);
      for (int i = 0; i < 7; i++) begin probe = 4'(i); tick(); end
      check("t4_in_post", 32'(busy), 32'(1));
      probe = 4'h9;
      do_arm(4'hF, 4'h5, 4'd1);
      probe = 4'h3; tick();
      probe = 4'h5; tick();
      probe = 4'h8; tick();
      check("t4_done", 32'(done), 32'(1));
      check("t4_trig_pos", 32'(trig_pos), 32'(1));
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("t4_rd0", 32'(rd_data), 32'(3));
      tick();
      check("t4_rd1", 32'(rd_data), 32'(5));
      check("t4_valid", 32'(rd_valid), 32'(1));

      // Asynchronous reset mid-readout, no clock edge in between.
      reset = 1'b0;
      #1;
      check("t4_rst_valid", 32'(rd_valid), 32'(0));
      check("t4_rst_done", 32'(done), 32'(0));
      check("t4_rst_data", 32'(rd_data), 32'(0));
      check("t4_rst_trig", 32'(trig_pos), 32'(0));
      #1;
      reset = 1'b1;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("t4_rdstart_ignored", 32'(rd_valid), 32'(0));
      check("t4_idle_busy", 32'(busy), 32'(0));

      // arm and rd_start together in DONE: arm wins.
      probe = 4'h2;
      do_arm(4'h0, 4'h0, 4'd0);
      tick();
      check("t5_done", 32'(done), 32'(1));
      arm = 1'b1; rd_start = 1'b1;
      tick();
      arm = 1'b0; rd_start = 1'b0;
      check("t5_busy", 32'(busy), 32'(1));
      check("t5_valid", 32'(rd_valid), 32'(0));
      tick();
      check("t5_done_again", 32'(done), 32'(1));
      check("t5_valid_again", 32'(rd_valid), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
